spi_burst_sequencer: RTL
========================

# spi_burst_sequencer

Byte-level frame sequencer between the SPI byte shifter and the configuration register memory, all in the SCLK domain. It decodes each SS-framed transaction as instruction, address MSB, address LSB, then a data stream, and drives auto-incrementing burst writes and reads against the memory. It also owns the persistent ready flags (`clk_div_ready`, `input_spike_ready`, `debug_config_ready`) that the core logic consumes.

## Interface
Parameters:
- `ADDR_W`, default 7: memory address width.
- `MEM_DEPTH`, default 128: number of valid addresses. Must satisfy `MEM_DEPTH <= 2**ADDR_W`.

Ports:
- `SCLK`, input, 1: clock; all logic is on the rising edge.
- `RESET`, input, 1: asynchronous, active-high reset.
- `SS`, input, 1: slave select, active-low, sampled on SCLK.
- `rx_valid`, input, 1: one-cycle pulse; `rx_byte` is valid in that cycle.
- `rx_byte`, input, 8: received byte.
- `mem_rdata`, input, 8: combinational read data at `mem_addr`.
- `mem_addr`, output, ADDR_W: memory address.
- `mem_wdata`, output, 8: write data.
- `mem_we`, output, 1: write strobe, one cycle per byte.
- `tx_byte`, output, 8: next byte for MISO.
- `clk_div_ready`, output, 1: persistent flag.
- `input_spike_ready`, output, 1: persistent flag.
- `debug_config_ready`, output, 1: persistent flag.
- `busy`, output, 1: high when the state is not `S_INSTR`.
- `addr_err`, output, 1: sticky; set by an out-of-range access.

## Operation
- States: `S_INSTR`, `S_ADDR_H`, `S_ADDR_L`, `S_WDATA`, `S_RDATA`, `S_IGNORE`.
- Opcodes:
  - 0x01: WRITE.
  - 0x02: READ.
  - 0x10: set `clk_div_ready`.
  - 0x11: set `input_spike_ready`.
  - 0x12: set `debug_config_ready`.
  - 0x1F: clear all three flags.
  - Any other value: go to `S_IGNORE`.
- Transitions (each step requires `rx_valid` with `SS`=0):
  - `S_INSTR`: on WRITE or READ, go to `S_ADDR_H` and latch the opcode. On a flag opcode, update the flags and go to `S_IGNORE`.
  - `S_ADDR_H`: latch the MSB and go to `S_ADDR_L`.
  - `S_ADDR_L`: form the address as {MSB, LSB} truncated to ADDR_W. If the full 16-bit value is ≥ MEM_DEPTH, set `addr_err` and go to `S_IGNORE`. Otherwise go to `S_WDATA` or `S_RDATA`.
  - `S_WDATA`: on each byte, drive `mem_we`=1, `mem_wdata`=`rx_byte` at the current address, then advance the address.
  - `S_RDATA`: on each byte (the master's dummy byte), advance the address. `tx_byte` is reloaded from `mem_rdata` on the cycle after the address changes.
  - Entering `S_RDATA` loads `tx_byte` with `mem_rdata` at the start address.
- `SS`=1 sampled at any edge forces `S_INSTR` and `mem_we`=0. A partial address or opcode is discarded. Flags and `addr_err` are kept.
- `rx_valid` while `SS`=1 is ignored.
- `addr_err` is cleared only by `RESET`.
- A flag set and a clear-all cannot occur in the same byte, because they are separate opcodes.

## Timing
- Reset values:
  - state: `S_INSTR`.
  - `mem_addr`, `mem_wdata`, `tx_byte`: 0.
  - `mem_we`: 0.
  - All flags, `busy`, `addr_err`: 0.
- All outputs are registered.
- `mem_we` is high exactly in the cycle after the `rx_valid` that carries the data byte. `mem_addr` and `mem_wdata` are stable in that cycle.
- The address advances in the cycle after `mem_we`.
- Back-to-back `rx_valid` pulses are at least 8 SCLK apart (a byte period), so no stall is needed.
- Flags update 1 cycle after the opcode's `rx_valid`.
- READ latency: `tx_byte` is valid 2 cycles after the `rx_valid` of the LSB or data byte, well within one byte period.
- An asynchronous `RESET` mid-burst aborts the burst immediately. No write strobe is issued after `RESET` asserts.

## Configuration
- Macro `SPI_BURST_ADDR_WRAP_EN` defined: after address MEM_DEPTH-1, the address wraps to 0 and the burst continues.
- Macro undefined: the address saturates at MEM_DEPTH-1. The next data byte is not written (no `mem_we`), `addr_err` is set, and the state becomes `S_IGNORE`.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum;
  - opcode constants (`OP_WRITE`, `OP_READ`, `OP_SET_CLKDIV`, `OP_SET_SPIKE`, `OP_SET_DEBUG`, `OP_CLR_FLAGS`);
  - the default `ADDR_W` and `MEM_DEPTH`.
- One sub-module, `spi_addr_counter`: loads, increments, applies wrap/saturate, and flags range errors.

## Test plan
- Write burst: opcode 0x01, address 0x00,0x05, data 0xAA,0xBB,0xCC. Expect `mem_we` ×3 at addresses 5, 6, 7 with data 0xAA, 0xBB, 0xCC, and `addr_err`=0.
- Read burst: memory preloaded with [5]=0x11, [6]=0x22. Opcode 0x02, address 0x00,0x05, two dummy bytes. Expect `tx_byte` = 0x11, then 0x22, and `mem_we` never asserted.
- Flags: opcodes 0x10, then 0x12 in separate frames. Expect `clk_div_ready`=1 and `debug_config_ready`=1 with `input_spike_ready`=0. Opcode 0x1F then clears all three to 0.
- Boundary: write from address 127 with 2 data bytes.
  - Wrap macro defined: writes land at 127, then 0.
  - Macro undefined: one write at 127, then `addr_err`=1.
- Abort: `SS` raised after the address MSB byte, then a new frame writes 0x01,0x00,0x03,0x5A. Expect a single write of 0x5A at address 3.
- Reset mid-burst: `RESET` pulsed between data bytes. Expect all outputs at reset values, no further `mem_we`, and the state back at `S_INSTR`.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI burst sequencer.
// Used by spi_burst_sequencer, spi_addr_counter and spi_burst_sequencer_if.
package spi_pkg;

    typedef enum logic [2:0] {
        S_INSTR  = 3'd0,
        S_ADDR_H = 3'd1,
        S_ADDR_L = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;
    localparam logic [7:0] OP_SET_CLKDIV = 8'h10;
    localparam logic [7:0] OP_SET_SPIKE  = 8'h11;
    localparam logic [7:0] OP_SET_DEBUG  = 8'h12;
    localparam logic [7:0] OP_CLR_FLAGS  = 8'h1F;

    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_MEM_DEPTH = 128;

endpackage

// File: rtl/spi_burst_sequencer_if.sv
// Register-memory bus between the sequencer (master) and the config memory (slave).
interface spi_burst_sequencer_if #(
    parameter int ADDR_W = spi_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/spi_addr_counter.sv
// Burst address register: load, increment, wrap or saturate, range check.
// SPI_BURST_ADDR_WRAP_EN selects wrap-to-zero instead of saturate-and-stop.
module spi_addr_counter
    import spi_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [15:0]       load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              exhausted,
    output logic              changed,
    output logic              load_oob
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              exhausted_q, exhausted_d;
    logic              changed_q, changed_d;

    // Range is judged on the full 16-bit address before truncation.
    assign load_oob = {16'd0, load_val} >= 32'(MEM_DEPTH);

    always_comb begin
        addr_d      = addr_q;
        exhausted_d = exhausted_q;
        changed_d   = 1'b0;
        if (load) begin
            addr_d      = load_val[ADDR_W-1:0];
            exhausted_d = 1'b0;
            changed_d   = 1'b1;
        end else if (inc && !exhausted_q) begin
            if (addr_q == LAST) begin
`ifdef SPI_BURST_ADDR_WRAP_EN
                addr_d    = '0;
                changed_d = 1'b1;
`else
                exhausted_d = 1'b1;
`endif
            end else begin
                addr_d    = addr_q + ADDR_W'(1);
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            addr_q      <= '0;
            exhausted_q <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            exhausted_q <= exhausted_d;
            changed_q   <= changed_d;
        end
    end

    assign addr      = addr_q;
    assign exhausted = exhausted_q;
    assign changed   = changed_q;

endmodule

// File: rtl/spi_burst_sequencer.sv
// SS-framed byte sequencer: opcode, address, then burst write/read data; owns the ready flags.
// Address end-of-range behaviour is chosen by SPI_BURST_ADDR_WRAP_EN (in spi_addr_counter).
module spi_burst_sequencer
    import spi_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                         SCLK,
    input  logic                         RESET,
    input  logic                         SS,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_byte,
    spi_burst_sequencer_if.master        mem,
    output logic [7:0]                   tx_byte,
    output logic                         clk_div_ready,
    output logic                         input_spike_ready,
    output logic                         debug_config_ready,
    output logic                         busy,
    output logic                         addr_err
);

    state_t      state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [7:0]  addr_h_q, addr_h_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  tx_q, tx_d;
    logic [2:0]  flags_q, flags_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic              cnt_load, cnt_inc, cnt_exhausted, cnt_changed, cnt_load_oob;
    logic [ADDR_W-1:0] cnt_addr;

    spi_addr_counter #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_addr_counter (
        .SCLK      (SCLK),
        .RESET     (RESET),
        .load      (cnt_load),
        .load_val  ({addr_h_q, rx_byte}),
        .inc       (cnt_inc),
        .addr      (cnt_addr),
        .exhausted (cnt_exhausted),
        .changed   (cnt_changed),
        .load_oob  (cnt_load_oob)
    );

    // Writes advance the address in the cycle after the strobe; reads advance on the dummy byte.
    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        addr_h_d  = addr_h_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        tx_d      = tx_q;
        flags_d   = flags_q;
        err_d     = err_q;
        cnt_load  = 1'b0;
        cnt_inc   = we_q;

        if (SS) begin
            state_d = S_INSTR;
        end else if (rx_valid) begin
            case (state_q)
                S_INSTR: begin
                    state_d = S_IGNORE;
                    case (rx_byte)
                        OP_WRITE:      begin state_d = S_ADDR_H; is_read_d = 1'b0; end
                        OP_READ:       begin state_d = S_ADDR_H; is_read_d = 1'b1; end
                        OP_SET_CLKDIV: flags_d[0] = 1'b1;
                        OP_SET_SPIKE:  flags_d[1] = 1'b1;
                        OP_SET_DEBUG:  flags_d[2] = 1'b1;
                        OP_CLR_FLAGS:  flags_d = 3'b000;
                        default:       ;
                    endcase
                end
                S_ADDR_H: begin
                    addr_h_d = rx_byte;
                    state_d  = S_ADDR_L;
                end
                S_ADDR_L: begin
                    if (cnt_load_oob) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = is_read_q ? S_RDATA : S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (cnt_exhausted) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = rx_byte;
                    end
                end
                S_RDATA: begin
                    if (cnt_exhausted) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                S_IGNORE: ;
                default:  state_d = S_INSTR;
            endcase
        end

        if (state_q == S_RDATA && cnt_changed) begin
            tx_d = mem.mem_rdata;
        end

        busy_d = (state_d != S_INSTR);
    end

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_INSTR;
            is_read_q <= 1'b0;
            addr_h_q  <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            tx_q      <= 8'h00;
            flags_q   <= 3'b000;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            addr_h_q  <= addr_h_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            tx_q      <= tx_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign mem.mem_addr       = cnt_addr;
    assign mem.mem_wdata      = wdata_q;
    assign mem.mem_we         = we_q;
    assign tx_byte            = tx_q;
    assign clk_div_ready      = flags_q[0];
    assign input_spike_ready  = flags_q[1];
    assign debug_config_ready = flags_q[2];
    assign busy               = busy_q;
    assign addr_err           = err_q;

endmodule
